// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the async-FIFO read-side controller.
package fifo_rd_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    GAP   = 2'd1,
    FULL  = 2'd2
  } rd_state_e;

  // A pop may start when nothing is held, or when the held word leaves on this edge.
  function automatic logic pop_slot(input rd_state_e st, input logic ready);
    return (st == EMPTY) || ((st == FULL) && ready);
  endfunction

endpackage

// File: rtl/fifo_rd_xfer_cnt.sv
// Wrap-around count of words accepted by the consumer.
module fifo_rd_xfer_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pop controller: pops the FIFO into a held register and hands it
// out over valid/ready. FIFO_RD_CTRL_CNT_EN adds the xfer_cnt accept counter.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FIFO_RD_CTRL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
`endif
);

  rd_state_e             state_p1;
  rd_state_e             state_nxt;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_p1;

  // Stage p0 -> p1: state register
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // GAP never pops: the read pointer's Gray copy is one cycle behind r_inc.
  always_comb begin
    state_nxt = state_p1;
    unique case (state_p1)
      EMPTY: if (pop) state_nxt = GAP;
      GAP:   state_nxt = out_ready ? EMPTY : FULL;
      FULL: begin
        if (pop)            state_nxt = GAP;
        else if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    pop       = !r_rst && rd_en && !r_empty && pop_slot(state_p1, out_ready);
    r_inc     = pop;
    out_valid = (state_p1 != EMPTY);
  end

  // Stage p0 -> p1: held word, loaded on every pop edge
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      data_p1 <= '0;
    end else if (pop) begin
      data_p1 <= r_data;
    end
  end

  assign out_data = data_p1;

`ifdef FIFO_RD_CTRL_CNT_EN
  fifo_rd_xfer_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_xfer_cnt (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .inc   (out_valid && out_ready),
    .cnt   (xfer_cnt)
  );
`else
  logic [CNT_WIDTH-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized and directed bench for fifo_rd_ctrl against a word-level model.
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          r_clk;
  logic          r_rst;
  logic          r_empty;
  logic [DW-1:0] r_data;
  logic          r_inc;
  logic          rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef FIFO_RD_CTRL_CNT_EN
  logic [CW-1:0] xfer_cnt;
`endif

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .r_inc     (r_inc),
    .rd_en     (rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_RD_CTRL_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int n_vec = 0;
  int n_err = 0;
  int n_inc = 0;

  // Bench-side FIFO contents and the ordered list of words not yet delivered.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];

  // Reference: is a word held, its value, cycles since it was loaded, accept count.
  logic          m_held = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_age  = 0;
  logic [CW-1:0] m_cnt  = '0;
  logic          prev_inc = 1'b0;

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
  endtask

  task automatic tick();
    logic exp_pop;
    logic acc;
    logic seen_inc;
    r_empty = (fq.size() == 0);
    r_data  = r_empty ? DW'($urandom) : fq[0];
    @(negedge r_clk);
    exp_pop = !r_rst && rd_en && !r_empty && (!m_held || (m_age >= 1 && out_ready));
    acc     = !r_rst && m_held && out_ready;
    n_vec++;
    if (r_inc !== exp_pop) begin
      n_err++;
      $display("FAIL r_inc: got %b want %b at %0t", r_inc, exp_pop, $time);
    end
    n_vec++;
    if (out_valid !== m_held) begin
      n_err++;
      $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_held, $time);
    end
    if (m_held) begin
      n_vec++;
      if (out_data !== m_data) begin
        n_err++;
        $display("FAIL out_data: got %h want %h at %0t", out_data, m_data, $time);
      end
    end
    n_vec++;
    if (r_inc === 1'b1 && prev_inc) begin
      n_err++;
      $display("FAIL r_inc_consecutive: got 1 want 0 at %0t", $time);
    end
    if (acc) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL order: got %h want none (duplicate) at %0t", out_data, $time);
      end else begin
        if (out_data !== sb[0]) begin
          n_err++;
          $display("FAIL order: got %h want %h at %0t", out_data, sb[0], $time);
        end
        void'(sb.pop_front());
      end
    end
`ifdef FIFO_RD_CTRL_CNT_EN
    n_vec++;
    if (xfer_cnt !== m_cnt) begin
      n_err++;
      $display("FAIL xfer_cnt: got %0d want %0d at %0t", xfer_cnt, m_cnt, $time);
    end
`endif
    seen_inc = (r_inc === 1'b1);
    @(posedge r_clk);
    if (r_rst) begin
      if (m_held && sb.size() > 0) void'(sb.pop_front());
      m_held = 1'b0;
      m_data = '0;
      m_cnt  = '0;
    end else begin
      if (acc) m_cnt = m_cnt + 1'b1;
      if (exp_pop) begin
        m_held = 1'b1;
        m_data = r_data;
        m_age  = 0;
      end else if (acc) begin
        m_held = 1'b0;
      end else if (m_held) begin
        m_age++;
      end
    end
    if (seen_inc && fq.size() > 0) begin
      void'(fq.pop_front());
      n_inc++;
    end
    prev_inc = seen_inc;
    #1;
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    fq.delete();
    sb.delete();
  endtask

  task automatic test_reset();
    push(8'h5A);
    repeat (2) tick();
    n_vec++;
    if (out_data !== 8'h00 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h want v=0 d=00", out_valid, out_data);
    end
`ifdef FIFO_RD_CTRL_CNT_EN
    n_vec++;
    if (xfer_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d want 0", xfer_cnt);
    end
`endif
    r_rst = 1'b0;
    fq.delete();
    sb.delete();
  endtask

  task automatic test_single();
    do_reset();
    rd_en = 1'b1;
    out_ready = 1'b1;
    tick();
    push(8'hA5);
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_err++;
      $display("FAIL single_load: got v=%b d=%h want v=1 d=a5", out_valid, out_data);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    rd_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    n_inc = 0;
    repeat (12) tick();
    n_vec++;
    if (n_inc !== 4 || sb.size() !== 0) begin
      n_err++;
      $display("FAIL stream: got pops=%0d left=%0d want pops=4 left=0", n_inc, sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rd_en = 1'b1;
    out_ready = 1'b0;
    push(8'h3C);
    push(8'h77);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
        n_err++;
        $display("FAIL backpressure_hold: got v=%b d=%h want v=1 d=3c", out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      n_err++;
      $display("FAIL backpressure_reload: got v=%b d=%h want v=1 d=77", out_valid, out_data);
    end
    repeat (2) tick();
  endtask

  task automatic test_rd_en_drop();
    do_reset();
    rd_en = 1'b1;
    out_ready = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (2) tick();
    rd_en = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || fq.size() !== 2) begin
        n_err++;
        $display("FAIL rd_en_drop: got v=%b fifo=%0d want v=0 fifo=2", out_valid, fq.size());
      end
    end
    rd_en = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rd_en     = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0 && fq.size() < 8) push(DW'($urandom));
      r_rst     = ($urandom_range(0, 60) == 0);
      tick();
    end
    r_rst = 1'b0;
  endtask

`ifdef FIFO_RD_CTRL_CNT_EN
  task automatic test_counter();
    int budget;
    do_reset();
    rd_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(DW'(i + 8'h40));
    budget = 0;
    while (sb.size() != 0 && budget < 60) begin
      tick();
      budget++;
    end
    n_vec++;
    if (sb.size() != 0 || xfer_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL counter_wrap: got cnt=%0d left=%0d want cnt=1 left=0", xfer_cnt, sb.size());
    end
    push(8'h9E);
    push(8'h9F);
    repeat (3) tick();
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    n_vec++;
    if (xfer_cnt !== 4'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL counter_reset: got cnt=%0d v=%b want cnt=0 v=0", xfer_cnt, out_valid);
    end
    fq.delete();
    sb.delete();
  endtask
`endif

  initial begin
    r_rst     = 1'b1;
    rd_en     = 1'b0;
    out_ready = 1'b0;
    r_empty   = 1'b1;
    r_data    = '0;
    @(posedge r_clk);
    #1;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_rd_en_drop();
    test_random();
`ifdef FIFO_RD_CTRL_CNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side pop controller for the asynchronous FIFO, clocked in the read domain, directly downstream of the FIFO read-pointer block. It drives `r_inc` against `r_empty` and captures the addressed FIFO word into an output register. It presents that word to the consumer (UART TX framer, ALU operand path) over a valid/ready handshake. It also enforces the one-cycle settle gap needed because the read-pointer block registers its Gray pointer one cycle after `r_inc`.

## Interface
- `DATA_WIDTH`, default 8: FIFO word width.
- `CNT_WIDTH`, default 16: transfer-counter width (used only with `FIFO_RD_CTRL_CNT_EN`).
- `r_clk` in 1: read-domain clock. All logic is on the rising edge.
- `r_rst` in 1: reset, synchronous, active-high.
- `r_empty` in 1: FIFO empty flag from the read-pointer block.
- `r_data` in DATA_WIDTH: FIFO memory read data at the current `r_addr`. Combinational and valid whenever `r_empty`=0.
- `r_inc` out 1: pop strobe to the read-pointer block. Combinational, one cycle per word.
- `rd_en` in 1: enables new pops. A word already held is still delivered while `rd_en`=0.
- `out_data` out DATA_WIDTH: held word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts when `out_valid & out_ready` at a rising edge.
- `xfer_cnt` out CNT_WIDTH: count of words accepted by the consumer. Present only with the macro.

## Operation
- FSM states:
  - EMPTY: no word held.
  - GAP: a word was loaded on the previous edge; pointer settling.
  - FULL: a word is held and the settle cycle is complete.
- `out_valid` = (state != EMPTY).
- `pop` = `!r_rst & rd_en & !r_empty & ((state==EMPTY) | (state==FULL & out_ready))`. `r_inc` = `pop`.
- `r_inc` is never high in GAP, so it is never asserted on two consecutive cycles.
- On a pop edge, `out_data` <= `r_data` and the next state is GAP.
- Transitions:
  - EMPTY: pop → GAP, else EMPTY.
  - GAP: `out_ready` → EMPTY, else FULL.
  - FULL: pop → GAP (consume and reload on the same edge). `out_ready` & !pop → EMPTY. !`out_ready` → FULL.
- `out_data` holds its value in FULL and after the word is consumed. The value in EMPTY is don't-care but must be stable.
- `rd_en` falling while in FULL: the held word is still delivered, then the state is EMPTY.
- `r_empty` rising while in FULL: no pop; the state goes to EMPTY on accept.
- Wrap-around of the FIFO pointer needs no special handling here.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `out_data` 0, `r_inc` 0 (forced low while `r_rst`=1), `xfer_cnt` 0.
- Latency: `r_empty` falls in cycle T (state EMPTY, `rd_en`=1) → `r_inc`=1 in T → `out_valid`=1 in T+1, with `out_data` equal to `r_data` sampled in T.
- Peak throughput: one word per 2 cycles (pop, gap, pop, ...), given `out_ready` held high.
- With `out_ready` low, `out_valid` and `out_data` stay stable until accepted. No word is dropped or duplicated.
- Reset asserted mid-operation: the held word is discarded and the state is EMPTY on the next edge. The FIFO pointer is not rewound; FIFO reset is the system's responsibility.

## Configuration
- Macro `FIFO_RD_CTRL_CNT_EN`.
- Defined: `xfer_cnt` increments by 1 on every `out_valid & out_ready` edge and wraps modulo 2^CNT_WIDTH. It clears on `r_rst`.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `fifo_rd_pkg` contains:
  - the state enum (EMPTY, GAP, FULL);
  - default `DATA_WIDTH`/`CNT_WIDTH` constants shared with the FIFO top.
- Sub-module `fifo_rd_xfer_cnt`: the wrap-around counter, instantiated only under the macro.

## Test plan
- Reset: hold `r_rst`=1 for 3 cycles with `r_empty`=0 → `r_inc`=0, `out_valid`=0, `out_data`=0, `xfer_cnt`=0.
- Single word: `r_empty`=0 with `r_data`=8'hA5 in T, `rd_en`=1, `out_ready`=1 → `r_inc`=1 in T only; `out_valid`=1 with 8'hA5 in T+1; `out_valid`=0 in T+2 if `r_empty`=1.
- Streaming: 4 words 8'h01–8'h04 queued, `out_ready`=1 → `r_inc` pulses on alternating cycles; outputs 01, 02, 03, 04 in order; `r_inc` never high on two consecutive cycles.
- Backpressure: load 8'h3C, `out_ready`=0 for 5 cycles → `out_valid`=1 and `out_data`=8'h3C stable, no `r_inc` while the FIFO is non-empty. On `out_ready`=1 the reload happens on the same edge.
- `rd_en` drop: `rd_en`→0 while in FULL → the held word is accepted, then `out_valid`=0 and no `r_inc` despite `r_empty`=0.
- Counter (macro on): CNT_WIDTH=4, accept 17 words → `xfer_cnt`=1 (wrapped). A mid-stream reset clears it to 0 and `out_valid`=0.
